// File: rtl/tune_pkg.sv
// Shared definitions for the tune trigger and the tune player: sequencer states
// and lockout lengths for both simulation-scaled and full-length tunes.
package tune_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_LOCK = 2'd2
  } tune_state_e;

  localparam int unsigned LOCK_CNT_W    = 27;
  localparam int unsigned LOCK_CYC_FAST = (1 << 22) + 16;
  localparam int unsigned LOCK_CYC_FULL = (1 << 26) + 16;

  function automatic int unsigned lock_cyc_sel(input int unsigned fast_sim);
    return (fast_sim != 0) ? LOCK_CYC_FAST : LOCK_CYC_FULL;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout down-counter: loads LOAD_VAL, counts to zero and parks there.
// clr wins over load, load wins over counting.
module lock_timer
  import tune_pkg::*;
#(
  parameter logic [LOCK_CNT_W-1:0] LOAD_VAL = LOCK_CNT_W'(LOCK_CYC_FAST - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clr,
  input  logic                  en,
  output logic [LOCK_CNT_W-1:0] cnt,
  output logic                  zero
);

  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - LOCK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tune_trigger.sv
// Turns tour-logic request edges into spaced start pulses for the tune player,
// queueing up to PEND_MAX requests and holding off while a tune is sounding.
//
// state | meaning
// IDLE  | waiting for a queued request with sound enabled
// FIRE  | one-cycle start pulse to the player, lock timer loaded
// LOCK  | tune playing, lock timer counting down to zero
module tune_trigger
  import tune_pkg::*;
#(
  parameter int unsigned FAST_SIM = 1,
  parameter int unsigned PEND_MAX = 3,
  parameter int unsigned LOCK_CYC = lock_cyc_sel(FAST_SIM)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       en,
  input  logic       flush,
  output logic       go,
  output logic       busy,
  output logic [1:0] pend,
  output logic       ovf
);

  localparam logic [1:0] PEND_LIM = 2'(PEND_MAX);

  tune_state_e           state_q, state_d;
  logic                  req_prev_q, req_prev_d;
  logic                  req_edge_q, req_edge_d;
  logic [1:0]            pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic                  go_q, go_d;
  logic                  busy_q, busy_d;
  logic                  fire, enq, drop;
  logic                  timer_load, timer_en, timer_zero;
  logic [LOCK_CNT_W-1:0] timer_cnt_unused;

  lock_timer #(
    .LOAD_VAL(LOCK_CNT_W'(LOCK_CYC - 1))
  ) u_lock_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .clr  (flush),
    .en   (timer_en),
    .cnt  (timer_cnt_unused),
    .zero (timer_zero)
  );

  always_comb begin
    req_prev_d = req;
    // an edge seen during flush is discarded along with the queue
    req_edge_d = req & ~req_prev_q & ~flush;

    fire = (state_q == ST_IDLE) && en && (pend_q != 2'd0) && !flush;
    enq  = req_edge_q && en && (pend_q < PEND_LIM);
    drop = req_edge_q && en && (pend_q >= PEND_LIM);

    timer_load = 1'b0;
    timer_en   = (state_q == ST_LOCK);
    state_d    = state_q;
    case (state_q)
      ST_IDLE: if (fire) state_d = ST_FIRE;
      ST_FIRE: begin
        state_d    = ST_LOCK;
        timer_load = 1'b1;
      end
      ST_LOCK: if (timer_zero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      pend_d  = 2'd0;
      ovf_d   = 1'b0;
    end else begin
      pend_d = en ? (pend_q + {1'b0, enq} - {1'b0, fire}) : 2'd0;
      ovf_d  = ovf_q | drop;
    end

    go_d   = (state_d == ST_FIRE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // history keeps sampling through reset so a req already high is not an edge
    req_prev_q <= req_prev_d;
    if (rst) begin
      state_q    <= ST_IDLE;
      req_edge_q <= 1'b0;
      pend_q     <= 2'd0;
      ovf_q      <= 1'b0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_edge_q <= req_edge_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      go_q       <= go_d;
      busy_q     <= busy_d;
    end
  end

  assign go   = go_q;
  assign busy = busy_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_tune_trigger.sv
// Self-checking bench for tune_trigger: vector table, directed corner sequences
// and a randomized run compared every cycle against a timestamp-based model.
module tb_tune_trigger;

  localparam int    LC       = 1024;
  localparam int    PMAX     = 3;
  localparam longint NEVER   = -100000;

  logic       clk = 1'b0;
  logic       rst, req, en, flush;
  logic       go, busy, ovf;
  logic [1:0] pend;

  int     n_checks = 0;
  int     n_err    = 0;
  longint cyc      = 0;

  // reference model: queue depth, sticky flag, and the cycle of the last go
  int     m_pend;
  bit     m_ovf, m_arrive, m_prev;
  longint m_fire_t = NEVER;

  tune_trigger #(
    .FAST_SIM (1),
    .PEND_MAX (PMAX),
    .LOCK_CYC (LC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (en),
    .flush (flush),
    .go    (go),
    .busy  (busy),
    .pend  (pend),
    .ovf   (ovf)
  );

  always #10 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // advances the model from cycle cyc to cyc+1 using the inputs now applied
  task automatic model_step();
    longint c = cyc;
    bit     firing;
    bit     inc;
    if (rst || flush) begin
      m_pend   = 0;
      m_ovf    = 0;
      m_fire_t = NEVER;
      m_arrive = 0;
    end else begin
      firing = (c > m_fire_t + LC) && en && (m_pend > 0);
      inc    = 0;
      if (m_arrive && en) begin
        if (m_pend < PMAX) inc = 1;
        else m_ovf = 1;
      end
      m_pend = en ? (m_pend + int'(inc) - int'(firing)) : 0;
      if (firing) m_fire_t = c + 1;
      m_arrive = req && !m_prev;
    end
    m_prev = req;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [4:0] exp_o;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    exp_o = {cyc == m_fire_t, (cyc >= m_fire_t) && (cyc <= m_fire_t + LC),
             2'(m_pend), m_ovf};
    n_checks++;
    if ({go, busy, pend, ovf} !== exp_o) begin
      n_err++;
      $display("FAIL model at cycle %0d: got go/busy/pend/ovf=%b, expected %b",
               cyc, {go, busy, pend, ovf}, exp_o);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; en = 1'b1; flush = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_req();
    req = 1'b1; step();
    req = 1'b0; step();
  endtask

  task automatic wait_go(output longint t);
    int n = 0;
    while (go !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("wait_go_timeout", longint'(go === 1'b1), 1);
    t = cyc;
  endtask

  typedef struct packed {
    logic       rst, req, en, flush;
    logic       go, busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t   tbl [15];
  longint t_go, t_edge, t_end, t_prev;
  int     ngo, nbusy;

  initial begin
    rst = 1'b1; req = 1'b0; en = 1'b1; flush = 1'b0;

    // {rst req en flush} {go busy pend ovf}: outputs seen the cycle after
    tbl[0]  = {4'b1010, 5'b00_00_0};
    tbl[1]  = {4'b0110, 5'b00_00_0};
    tbl[2]  = {4'b0110, 5'b00_01_0};
    tbl[3]  = {4'b0110, 5'b11_00_0};
    tbl[4]  = {4'b0010, 5'b01_00_0};
    tbl[5]  = {4'b0110, 5'b01_00_0};
    tbl[6]  = {4'b0010, 5'b01_01_0};
    tbl[7]  = {4'b0110, 5'b01_01_0};
    tbl[8]  = {4'b0010, 5'b01_10_0};
    tbl[9]  = {4'b0110, 5'b01_10_0};
    tbl[10] = {4'b0010, 5'b01_11_0};
    tbl[11] = {4'b0110, 5'b01_11_0};
    tbl[12] = {4'b0010, 5'b01_11_1};
    tbl[13] = {4'b0011, 5'b00_00_0};
    tbl[14] = {4'b0010, 5'b00_00_0};

    for (int i = 0; i < 15; i++) begin
      {rst, req, en, flush} = {tbl[i].rst, tbl[i].req, tbl[i].en, tbl[i].flush};
      step();
      check($sformatf("table_row%0d", i), longint'({go, busy, pend, ovf}),
            longint'({tbl[i].go, tbl[i].busy, tbl[i].pend, tbl[i].ovf}));
    end
    flush = 1'b0;

    // single request: latency, busy length, queue drains
    do_reset();
    t_edge = cyc;
    pulse_req();
    ngo = 0; nbusy = 0; t_go = 0;
    for (int i = 0; i < LC + 20; i++) begin
      step();
      if (go === 1'b1) begin ngo++; t_go = cyc; end
      if (busy === 1'b1) nbusy++;
    end
    check("single_go_count", ngo, 1);
    check("single_go_latency", t_go - t_edge, 3);
    check("single_busy_len", nbusy, LC + 1);
    check("single_pend_end", pend, 0);

    // queueing: four edges during LOCK, one dropped; LC+1 idle cycles between pulses
    do_reset();
    pulse_req();
    wait_go(t_go);
    for (int i = 0; i < 4; i++) pulse_req();
    step();
    check("queue_pend_full", pend, 3);
    check("queue_ovf_set", ovf, 1);
    ngo = 0; t_prev = t_go;
    for (int i = 0; i < 3 * (LC + 2) + 50; i++) begin
      step();
      if (go === 1'b1) begin
        ngo++;
        check("queue_go_period", cyc - t_prev, LC + 2);
        t_prev = cyc;
      end
    end
    check("queue_go_count", ngo, 3);
    check("queue_pend_end", pend, 0);
    check("queue_ovf_sticky", ovf, 1);

    // held request: one pulse only
    do_reset();
    ngo = 0;
    req = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (go === 1'b1) ngo++;
    end
    req = 1'b0;
    for (int i = 0; i < LC + 50; i++) begin
      step();
      if (go === 1'b1) ngo++;
    end
    check("held_go_count", ngo, 1);

    // disable during LOCK: queue cleared, lockout completes, nothing fires
    do_reset();
    pulse_req();
    wait_go(t_go);
    pulse_req();
    pulse_req();
    step();
    check("disable_pend_pre", pend, 2);
    en = 1'b0;
    step();
    check("disable_pend_clear", pend, 0);
    ngo = 0; t_end = 0;
    for (int i = 0; i < LC + 20; i++) begin
      step();
      if (go === 1'b1) ngo++;
      if (busy !== 1'b1 && t_end == 0) t_end = cyc;
    end
    check("disable_lock_len", t_end - t_go, LC + 1);
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (go === 1'b1) ngo++;
    end
    check("disable_no_go", ngo, 0);

    // flush mid-LOCK together with a new request edge
    do_reset();
    pulse_req();
    wait_go(t_go);
    pulse_req();
    step();
    check("flush_pend_pre", pend, 1);
    flush = 1'b1; req = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_pend", pend, 0);
    check("flush_ovf", ovf, 0);
    ngo = (go === 1'b1) ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) req = 1'b0;
      step();
      if (go === 1'b1) ngo++;
    end
    check("flush_no_go", ngo, 0);

    // reset when the lock counter holds 1000, req held high across reset
    do_reset();
    pulse_req();
    wait_go(t_go);
    while (cyc < t_go + LC - 1000) step();
    rst = 1'b1; req = 1'b1;
    step();
    check("reset_go", go, 0);
    check("reset_busy", busy, 0);
    check("reset_pend", pend, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b0;
    ngo = 0;
    for (int i = 0; i < LC + 50; i++) begin
      step();
      if (go === 1'b1) ngo++;
    end
    check("reset_held_req_no_go", ngo, 0);
    req = 1'b0;

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 5) == 0) req = ~req;
      if (en) begin
        if ($urandom_range(0, 2999) == 0) en = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        en = 1'b1;
      end
      flush = ($urandom_range(0, 1499) == 0);
      rst   = ($urandom_range(0, 6999) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
